// File: rtl/traffic_light_controller.sv
// Single-approach traffic light: GREEN -> YELLOW -> RED with a BCD seconds countdown.
// Optional NIGHT flashing-yellow mode is compiled in when NIGHT_MODE_EN is defined.
module traffic_light_controller #(
  parameter int unsigned CLK_DIV     = 50000000,
  parameter int unsigned GREEN_TIME  = 25,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned RED_TIME    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
`ifdef NIGHT_MODE_EN
  input  logic       nightMode,
`endif
  output logic       secTick,
  output logic [2:0] ledSingle,
  output logic [3:0] controlLed7Seg1,
  output logic [3:0] controlLed7Seg0
);

  localparam int unsigned PresWidth = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PresWidth-1:0] PresMax = PresWidth'(CLK_DIV - 1);

  localparam logic [3:0] GreenTens   = 4'(GREEN_TIME / 10);
  localparam logic [3:0] GreenUnits  = 4'(GREEN_TIME % 10);
  localparam logic [3:0] YellowTens  = 4'(YELLOW_TIME / 10);
  localparam logic [3:0] YellowUnits = 4'(YELLOW_TIME % 10);
  localparam logic [3:0] RedTens     = 4'(RED_TIME / 10);
  localparam logic [3:0] RedUnits    = 4'(RED_TIME % 10);

  localparam logic [2:0] LedGreen  = 3'b100;
  localparam logic [2:0] LedYellow = 3'b010;
  localparam logic [2:0] LedRed    = 3'b001;

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StRed    = 2'd2,
    StNight  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PresWidth-1:0]   presc_q, presc_d;
  logic [2:0]             led_q, led_d;
  logic [3:0]             tens_q, tens_d;
  logic [3:0]             units_q, units_d;
  logic                   tick;

  assign tick = enable && (presc_q == PresMax);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    led_d   = led_q;
    tens_d  = tens_q;
    units_d = units_q;

    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
`ifdef NIGHT_MODE_EN
      if (nightMode && (state_q != StNight)) begin
        state_d = StNight;
        led_d   = LedYellow;
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (!nightMode && (state_q == StNight)) begin
        // Leave night with a full red phase and a fresh second.
        state_d = StRed;
        led_d   = LedRed;
        tens_d  = RedTens;
        units_d = RedUnits;
        presc_d = '0;
      end else if (state_q == StNight) begin
        if (tick) begin
          led_d = (led_q == LedYellow) ? 3'b000 : LedYellow;
        end
      end else
`endif
      if (tick) begin
        if ((tens_q == 4'd0) && (units_q == 4'd1)) begin
          case (state_q)
            StGreen: begin
              state_d = StYellow;
              led_d   = LedYellow;
              tens_d  = YellowTens;
              units_d = YellowUnits;
            end
            StYellow: begin
              state_d = StRed;
              led_d   = LedRed;
              tens_d  = RedTens;
              units_d = RedUnits;
            end
            default: begin
              state_d = StGreen;
              led_d   = LedGreen;
              tens_d  = GreenTens;
              units_d = GreenUnits;
            end
          endcase
        end else if (units_q == 4'd0) begin
          units_d = 4'd9;
          tens_d  = tens_q - 4'd1;
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRed;
      presc_q <= '0;
      led_q   <= LedRed;
      tens_q  <= RedTens;
      units_q <= RedUnits;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      led_q   <= led_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign secTick         = tick;
  assign ledSingle       = led_q;
  assign controlLed7Seg1 = tens_q;
  assign controlLed7Seg0 = units_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: an integer seconds model predicts every cycle.
module tb_traffic_light_controller;

  localparam int unsigned ClkDiv     = 4;
  localparam int unsigned GreenTime  = 5;
  localparam int unsigned YellowTime = 3;
  localparam int unsigned RedTime    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       night_mode = 1'b0;
  logic       sec_tick;
  logic [2:0] led_single;
  logic [3:0] seg_tens;
  logic [3:0] seg_units;

  int checks = 0;
  int failures = 0;

  // Model: phase 0=green 1=yellow 2=red, remaining seconds, prescaler.
  int m_phase = 2;
  int m_rem = 12;
  int m_presc = 0;
  logic [11:0] sb_q[$];

  traffic_light_controller #(
    .CLK_DIV    (ClkDiv),
    .GREEN_TIME (GreenTime),
    .YELLOW_TIME(YellowTime),
    .RED_TIME   (RedTime)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
`ifdef NIGHT_MODE_EN
    .nightMode      (night_mode),
`endif
    .secTick        (sec_tick),
    .ledSingle      (led_single),
    .controlLed7Seg1(seg_tens),
    .controlLed7Seg0(seg_units)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int phase_time(input int ph);
    case (ph)
      0:       return GreenTime;
      1:       return YellowTime;
      default: return RedTime;
    endcase
  endfunction

  function automatic logic [2:0] phase_led(input int ph);
    case (ph)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic model_update(input logic r, input logic en);
    bit t;
    if (r) begin
      m_phase = 2;
      m_rem   = RedTime;
      m_presc = 0;
    end else if (en) begin
      t = (m_presc == ClkDiv - 1);
      m_presc = t ? 0 : m_presc + 1;
      if (t) begin
        if (m_rem == 1) begin
          m_phase = (m_phase + 1) % 3;
          m_rem   = phase_time(m_phase);
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs, queue the prediction, then compare after the edge.
  task automatic step(input logic r, input logic en);
    logic [11:0] exp_v;
    logic [11:0] got_v;
    @(negedge clk);
    rst    = r;
    enable = en;
    model_update(r, en);
    exp_v = {(en && (m_presc == ClkDiv - 1)), phase_led(m_phase),
             4'(m_rem / 10), 4'(m_rem % 10)};
    sb_q.push_back(exp_v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_v = sb_q.pop_front();
      got_v = {sec_tick, led_single, seg_tens, seg_units};
      check_eq("cycle_out", 32'(got_v), 32'(exp_v));
    end
  endtask

  initial begin
    int first_tick;
    int p;
    int n;
    bit found;

    // Reset for two cycles.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_eq("rst_led", 32'(led_single), 32'h1);
    check_eq("rst_tens", 32'(seg_tens), 32'd1);
    check_eq("rst_units", 32'(seg_units), 32'd2);
    check_eq("rst_tick", 32'(sec_tick), 32'd0);

    // Free-run one full 80-cycle period.
    first_tick = 0;
    for (int i = 1; i <= 80; i++) begin
      step(1'b0, 1'b1);
      if (sec_tick && first_tick == 0) first_tick = i;
      if (i == 8) begin
        check_eq("cnt10_tens", 32'(seg_tens), 32'd1);
        check_eq("cnt10_units", 32'(seg_units), 32'd0);
      end
      if (i == 12) begin
        check_eq("cnt09_tens", 32'(seg_tens), 32'd0);
        check_eq("cnt09_units", 32'(seg_units), 32'd9);
      end
      if (i == 48) begin
        check_eq("red2green_led", 32'(led_single), 32'h4);
        check_eq("red2green_units", 32'(seg_units), 32'd5);
      end
      if (i == 80) begin
        check_eq("wrap_led", 32'(led_single), 32'h1);
        check_eq("wrap_tens", 32'(seg_tens), 32'd1);
        check_eq("wrap_units", 32'(seg_units), 32'd2);
      end
    end
    // Prescaler already reads 0 in the release cycle; the tick is its 4th cycle.
    check_eq("first_tick", 32'(first_tick), 32'(ClkDiv - 1));

    // Freeze mid-green at count 04.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == 0 && m_rem == 4 && m_presc == 1) found = 1;
      else step(1'b0, 1'b1);
    end
    check_eq("reach_green04", 32'(found), 32'd1);
    p = m_presc;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    check_eq("hold_tens", 32'(seg_tens), 32'd0);
    check_eq("hold_units", 32'(seg_units), 32'd4);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(1'b0, 1'b1);
      if (seg_units == 4'd3) n = i;
    end
    check_eq("resume_latency", 32'(n), 32'(ClkDiv - p));

    // Reset coincident with the final yellow tick.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == 1 && m_rem == 1 && m_presc == ClkDiv - 1) found = 1;
      else step(1'b0, 1'b1);
    end
    check_eq("reach_yellow01", 32'(found), 32'd1);
    check_eq("yellow01_tick", 32'(sec_tick), 32'd1);
    step(1'b1, 1'b1);
    check_eq("rst_tick_led", 32'(led_single), 32'h1);
    check_eq("rst_tick_tens", 32'(seg_tens), 32'd1);
    check_eq("rst_tick_units", 32'(seg_units), 32'd2);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
